// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for mem_port_arbiter.
//   arbState_t : FSM encoding (IDLE, BUSY)
//   minWidth() : counter/index width helper, never less than 1 bit
//   CH_DATA, CH_INST : fixed channel indices used by the CPU pipeline
package mem_arb_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arbState_t;
    localparam int CH_DATA = 0;
    localparam int CH_INST = 1;
    function automatic int minWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_arb_prio_enc.sv
// mem_arb_prio_enc: lowest-index-first priority encoder.
//   pending  in  N     : request vector
//   grantIdx out IW    : index of lowest set bit (0 when none)
//   anyValid out 1     : at least one bit set
module mem_arb_prio_enc #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  pending,
    output logic [IW-1:0] grantIdx,
    output logic          anyValid
);
    always_comb begin
        grantIdx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pending[i]) grantIdx = IW'(i);
        anyValid = |pending;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fixed-priority arbiter and stall generator merging NUM_CH
// pipeline channels onto one fixed-latency memory port.
//   clk, reset_n (async, active-low)
//   req_valid/req_write [NUM_CH], req_addr/req_wdata [NUM_CH*WORD_SIZE] : channel requests
//   req_ready [NUM_CH]  : registered one-cycle completion pulse
//   rsp_rdata           : registered read data, valid with req_ready
//   stall               : combinational, high while any request is pending
//   mem_read/mem_write, mem_addr/mem_wdata, mem_rdata : memory port
// Optional MEM_ARB_WRITE_BUFFER_EN: one-entry posted write buffer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int NUM_CH      = 2,
    parameter int MEM_LATENCY = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CH-1:0]           req_valid,
    input  logic [NUM_CH-1:0]           req_write,
    input  logic [NUM_CH*WORD_SIZE-1:0] req_addr,
    input  logic [NUM_CH*WORD_SIZE-1:0] req_wdata,
    output logic [NUM_CH-1:0]           req_ready,
    output logic [WORD_SIZE-1:0]        rsp_rdata,
    output logic                        stall,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [WORD_SIZE-1:0]        mem_addr,
    output logic [WORD_SIZE-1:0]        mem_wdata,
    input  logic [WORD_SIZE-1:0]        mem_rdata
);
    localparam int IDX_W = minWidth(NUM_CH);
    localparam int CNT_W = minWidth(MEM_LATENCY);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);
`ifdef MEM_ARB_WRITE_BUFFER_EN
    // A granted write is acknowledged at capture; the busy write access is the buffer drain.
    localparam bit POST_WRITES = 1'b1;
`else
    localparam bit POST_WRITES = 1'b0;
`endif

    arbState_t         state, stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  grantQ, encIdx;
    logic              wrQ, encAny, lastBeat, doGrant;
    logic [NUM_CH-1:0] doneQ, pending, servingMask, readyNext;

    assign pending  = req_valid & ~doneQ & ~req_ready;
    // Held at 0 during reset so every output reads 0 while reset_n is low.
    assign stall    = reset_n & (|pending);
    assign lastBeat = (state == BUSY) && (cnt == LAST_CNT);
    // The channel being served is excluded so a regrant never picks it again.
    assign servingMask = (state == BUSY) ? (NUM_CH'(1) << grantQ) : '0;
    assign doGrant  = encAny && ((state == IDLE) || lastBeat);
    assign mem_read  = (state == BUSY) && !wrQ;
    assign mem_write = (state == BUSY) && wrQ;

    mem_arb_prio_enc #(.N(NUM_CH), .IW(IDX_W)) prioEnc (
        .pending  (pending & ~servingMask),
        .grantIdx (encIdx),
        .anyValid (encAny)
    );

    always_comb begin
        stateNext = doGrant ? BUSY : (lastBeat ? IDLE : state);
        readyNext = '0;
        if (lastBeat && !(POST_WRITES && wrQ)) readyNext[grantQ] = 1'b1;
        if (doGrant && POST_WRITES && req_write[encIdx]) readyNext[encIdx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            grantQ    <= '0;
            wrQ       <= 1'b0;
            doneQ     <= '0;
            req_ready <= '0;
            rsp_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            req_ready <= readyNext;
            doneQ     <= stall ? (doneQ | req_ready) : '0;
            cnt       <= (doGrant || lastBeat) ? '0 : ((state == BUSY) ? cnt + 1'b1 : cnt);
            if (doGrant) begin
                grantQ    <= encIdx;
                wrQ       <= req_write[encIdx];
                mem_addr  <= req_addr[encIdx*WORD_SIZE +: WORD_SIZE];
                mem_wdata <= req_wdata[encIdx*WORD_SIZE +: WORD_SIZE];
            end
            if (lastBeat && !wrQ) rsp_rdata <= mem_rdata;
        end
    end
endmodule
